// File: rtl/foc_ctrl_pkg.sv
// rtl/foc_ctrl_pkg.sv - shared constants, saturation helper and PI FSM states for the FOC outer loops
package foc_ctrl_pkg;

  // Integrator width; wide enough for MAX_IQ << SHIFT plus one Ki*err step.
  localparam int INTEG_W = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_PMUL,
    ST_INTEG,
    ST_SUM,
    ST_OUT
  } pi_state_t;

  // Width-generic signed clamp: callers sign-extend into 64 bits and slice the result back.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input logic signed [63:0] lo,
                                               input logic signed [63:0] hi);
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/speed_pi_ctrl_if.sv
// rtl/speed_pi_ctrl_if.sv - control-period strobe, angle, gains and speed/iq result bundle
// master: drives i_en, i_run, phi, speed_aim, Kp, Ki; receives o_en, speed, iq_aim
// slave : the speed loop itself
interface speed_pi_ctrl_if;
  logic               i_en;
  logic               i_run;
  logic [11:0]        phi;
  logic signed [15:0] speed_aim;
  logic [15:0]        Kp;
  logic [15:0]        Ki;
  logic               o_en;
  logic signed [15:0] speed;
  logic signed [15:0] iq_aim;

  modport master (
    output i_en, i_run, phi, speed_aim, Kp, Ki,
    input  o_en, speed, iq_aim
  );

  modport slave (
    input  i_en, i_run, phi, speed_aim, Kp, Ki,
    output o_en, speed, iq_aim
  );
endinterface

// File: rtl/speed_pi_ctrl_angle_speed_est.sv
// rtl/speed_pi_ctrl_angle_speed_est.sv - wrapped angle differencing and per-window speed accumulation
// clk, rst  : clock, synchronous active-high reset
// i_en      : one pulse per control period; phi is sampled on it
// phi       : 12-bit mechanical angle, wraps at 4096
// speed_s   : summed angle change of the last closed window
// win_done  : one-cycle pulse after the edge that closed a window
module angle_speed_est
  import foc_ctrl_pkg::*;
#(
  parameter logic [15:0] SPEED_DIV = 16'd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [11:0]        phi,
  output logic signed [15:0] speed_s,
  output logic               win_done
);

  logic [11:0]        phi_prev;
  logic               phi_valid;
  logic signed [15:0] acc;
  logic [15:0]        cnt;

  logic [11:0]        diff;
  logic signed [63:0] sum_ext;
  logic signed [63:0] sum_sat;
  logic signed [15:0] acc_next;
  logic [15:0]        cnt_next;

  always_comb begin
    // Modulo-4096 difference read as signed 12-bit gives the shortest way round the circle.
    diff     = phi - phi_prev;
    sum_ext  = 64'(acc);
    if (phi_valid) sum_ext = 64'(acc) + $signed({{52{diff[11]}}, diff});
    sum_sat  = sat_s(sum_ext, -64'sd32767, 64'sd32767);
    acc_next = sum_sat[15:0];
    cnt_next = cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phi_prev  <= 12'd0;
      phi_valid <= 1'b0;
      acc       <= 16'sd0;
      cnt       <= 16'd0;
      speed_s   <= 16'sd0;
      win_done  <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (i_en) begin
        phi_prev  <= phi;
        phi_valid <= 1'b1;
        // The priming pulse counts toward the window even though it adds nothing.
        if (cnt_next == SPEED_DIV) begin
          speed_s  <= acc_next;
          acc      <= 16'sd0;
          cnt      <= 16'd0;
          win_done <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: rtl/speed_pi_ctrl.sv
// rtl/speed_pi_ctrl.sv - outer speed PI loop producing the q-axis current target
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of speed_pi_ctrl_if (i_en, i_run, phi, speed_aim, Kp, Ki in;
//            o_en, speed, iq_aim out)
module speed_pi_ctrl
  import foc_ctrl_pkg::*;
#(
  parameter logic [15:0] SPEED_DIV = 16'd32,
  parameter logic [4:0]  SHIFT     = 5'd12,
  parameter logic [15:0] MAX_IQ    = 16'd400
) (
  input  logic           clk,
  input  logic           rst,
  speed_pi_ctrl_if.slave bus
);

  logic signed [15:0] speed_s;
  logic               win_done;

  angle_speed_est #(.SPEED_DIV(SPEED_DIV)) u_est (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.i_en),
    .phi      (bus.phi),
    .speed_s  (speed_s),
    .win_done (win_done)
  );

  pi_state_t                  state;
  logic signed [15:0]         spd;    // window result held for the whole computation
  logic signed [15:0]         err;
  logic signed [32:0]         p;
  logic signed [INTEG_W-1:0]  integ;

  logic signed [63:0] iq_lim, integ_lim;
  logic signed [63:0] err_full, err_sat;
  logic signed [15:0] err_w;
  logic signed [32:0] kp_x, err_x, p_w;
  logic signed [63:0] prod_i, integ_sum, integ_sat;
  logic signed [63:0] pi_sum, pi_shift, u_sat;
  logic signed [15:0] u_w;

  always_comb begin
    iq_lim    = $signed(64'(MAX_IQ));
    integ_lim = iq_lim <<< SHIFT;

    err_full  = 64'(bus.speed_aim) - 64'(spd);
    err_sat   = sat_s(err_full, -64'sd32768, 64'sd32767);
    err_w     = err_sat[15:0];

    kp_x      = $signed({17'd0, bus.Kp});
    err_x     = 33'(err);
    p_w       = kp_x * err_x;

    // Clamping the integrator to the output range keeps it from winding up.
    prod_i    = $signed({48'd0, bus.Ki}) * 64'(err);
    integ_sum = 64'(integ) + prod_i;
    integ_sat = sat_s(integ_sum, -integ_lim, integ_lim);

    pi_sum    = 64'(p) + 64'(integ);
    pi_shift  = pi_sum >>> SHIFT;
    u_sat     = sat_s(pi_shift, -iq_lim, iq_lim);
    u_w       = bus.i_run ? u_sat[15:0] : 16'sd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      spd        <= 16'sd0;
      err        <= 16'sd0;
      p          <= 33'sd0;
      integ      <= '0;
      bus.o_en   <= 1'b0;
      bus.speed  <= 16'sd0;
      bus.iq_aim <= 16'sd0;
    end else begin
      bus.o_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_done) begin
            spd   <= speed_s;
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          err   <= err_w;
          state <= ST_PMUL;
        end
        ST_PMUL: begin
          p     <= p_w;
          state <= ST_INTEG;
        end
        ST_INTEG: begin
          integ <= integ_sat[INTEG_W-1:0];
          state <= ST_SUM;
        end
        ST_SUM: begin
          // Results are registered here so they are visible, with o_en, during OUT.
          bus.speed  <= spd;
          bus.iq_aim <= u_w;
          bus.o_en   <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // Loop disabled: output parked at zero and the integrator restarts clean.
      if (!bus.i_run) begin
        integ      <= '0;
        bus.iq_aim <= 16'sd0;
      end
    end
  end

endmodule
